// File: rtl/arb_req_queue.sv
// Per-port request FIFOs feeding a round-robin arbiter; granted heads are
// popped onto one registered shared output bus.
module arb_req_queue #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          in_valid,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   output logic [NUM_PORTS-1:0]          in_ready,
   output logic [NUM_PORTS-1:0]          reqs,
   input  logic [NUM_PORTS-1:0]          grants,
   output logic                          out_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic [$clog2(NUM_PORTS)-1:0]  out_port,
   output logic                          grant_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = $clog2(NUM_PORTS);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

   logic [NUM_PORTS-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NUM_PORTS-1:0][PW-1:0] wptr_q, wptr_d;
   logic [NUM_PORTS-1:0][PW-1:0] rptr_q, rptr_d;
   logic [DATA_W-1:0]            mem_q [NUM_PORTS][DEPTH];

   logic              mask_q;
   logic              err_q, err_d;
   logic              vld_q, vld_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IW-1:0]     port_q, port_d;

   logic [NUM_PORTS-1:0] push;
   logic [NUM_PORTS-1:0] popv;
   logic [IW-1:0]        gidx;
   logic                 onehot;
   logic                 hit;
   logic                 pop;
   logic                 bad;

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grants[i]) gidx = IW'(i);
      end
      onehot = (grants != '0) && ((grants & (grants - ONE)) == '0);
      hit    = onehot && (cnt_q[gidx] != '0);
      // grants are masked for the single cycle following reset
      pop    = !mask_q && hit;
      bad    = !mask_q && (grants != '0) && !hit;
   end

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         in_ready[i] = (cnt_q[i] != FULL);
         reqs[i]     = cnt_q[i] > (grants[i] ? CW'(1) : CW'(0));
         push[i]     = in_valid[i] && in_ready[i];
         popv[i]     = pop && (gidx == IW'(i));
         cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(popv[i]);
         wptr_d[i]   = wptr_q[i] + PW'(push[i]);
         rptr_d[i]   = rptr_q[i] + PW'(popv[i]);
      end
   end

   always_comb begin
      vld_d  = pop;
      data_d = data_q;
      port_d = port_q;
      err_d  = err_q | bad;
      if (pop) begin
         data_d = mem_q[gidx][rptr_q[gidx]];
         port_d = gidx;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (push[i]) mem_q[i][wptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         mask_q <= 1'b1;
         err_q  <= 1'b0;
         vld_q  <= 1'b0;
         data_q <= '0;
         port_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         mask_q <= 1'b0;
         err_q  <= err_d;
         vld_q  <= vld_d;
         data_q <= data_d;
         port_q <= port_d;
      end
   end

   assign out_valid = vld_q;
   assign out_data  = data_q;
   assign out_port  = port_q;
   assign grant_err = err_q;

endmodule

// File: tb/tb_arb_req_queue.sv
// Scoreboard bench for arb_req_queue: queue-based reference model plus a
// model round-robin arbiter driving grants.
module tb_arb_req_queue;

   localparam int N = 4;
   localparam int W = 32;
   localparam int D = 4;

   typedef struct {
      logic        v;
      logic [1:0]  p;
      logic [31:0] d;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     in_valid = '0;
   logic [N*W-1:0]   in_data = '0;
   logic [N-1:0]     in_ready;
   logic [N-1:0]     reqs;
   logic [N-1:0]     grants = '0;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [1:0]       out_port;
   logic             grant_err;

   int          npass = 0;
   int          ntotal = 0;
   exp_t        sb[$];
   logic [31:0] mq [N][$];
   logic        merr = 1'b0;
   logic        mmask = 1'b0;
   logic [N-1:0] garb = '0;
   int          arb_last = N - 1;
   logic        arb_en = 1'b0;

   arb_req_queue #(.NUM_PORTS(N), .DATA_W(W), .DEPTH(D)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .reqs(reqs),
      .grants(grants),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_port(out_port),
      .grant_err(grant_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] x);
      ntotal++;
      if (a !== x)
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
      else
         npass++;
   endtask

   function automatic logic [N-1:0] rr(input logic [N-1:0] r);
      logic [N-1:0] g = '0;
      int idx;
      for (int k = 1; k <= N; k++) begin
         idx = (arb_last + k) % N;
         if (r[idx] && g == '0) begin
            g[idx] = 1'b1;
            arb_last = idx;
         end
      end
      return g;
   endfunction

   // one clock: apply inputs, check combinational outputs, advance model
   task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic [N-1:0] g, output logic [N-1:0] er);
      exp_t e;
      logic [N-1:0] rdy;
      int gi;
      in_valid = v;
      in_data  = d;
      grants   = g;
      #1;
      for (int i = 0; i < N; i++) begin
         er[i]  = mq[i].size() > (g[i] ? 1 : 0);
         rdy[i] = mq[i].size() < D;
      end
      chk("reqs", 64'(reqs), 64'(er));
      chk("in_ready", 64'(in_ready), 64'(rdy));
      e.v = 1'b0;
      e.p = '0;
      e.d = '0;
      if (!mmask && g != '0) begin
         gi = 0;
         for (int i = 0; i < N; i++) if (g[i]) gi = i;
         if (!$onehot(g) || mq[gi].size() == 0) begin
            merr = 1'b1;
         end else begin
            e.v = 1'b1;
            e.p = 2'(gi);
            e.d = mq[gi].pop_front();
         end
      end
      for (int i = 0; i < N; i++)
         if (v[i] && rdy[i]) mq[i].push_back(d[i*W +: W]);
      mmask = 1'b0;
      @(posedge clk);
      sb.push_back(e);
      #1;
      chk("grant_err", 64'(grant_err), 64'(merr));
   endtask

   task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d);
      logic [N-1:0] er;
      cyc(v, d, arb_en ? garb : '0, er);
      garb = arb_en ? rr(er) : '0;
   endtask

   task automatic run(input int n);
      repeat (n) step('0, '0);
   endtask

   task automatic do_reset(input logic [N-1:0] g);
      in_valid = '0;
      grants   = g;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_out_port", 64'(out_port), 64'(0));
      chk("rst_grant_err", 64'(grant_err), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(4'b1111));
      chk("rst_reqs", 64'(reqs), 64'(0));
      reset = 1'b0;
      for (int i = 0; i < N; i++) mq[i].delete();
      merr     = 1'b0;
      mmask    = 1'b1;
      garb     = '0;
      arb_last = N - 1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("out_valid", 64'(out_valid), 64'(e.v));
         if (e.v) begin
            chk("out_data", 64'(out_data), 64'(e.d));
            chk("out_port", 64'(out_port), 64'(e.p));
         end
      end
   end

   initial begin
      logic [N*W-1:0] d;
      logic [N-1:0]   er;
      logic [N-1:0]   gsave;

      do_reset('0);

      // single push on port 2
      arb_en = 1'b1;
      step('0, '0);
      d = '0;
      d[2*W +: W] = 32'hA5A5_0001;
      step(4'b0100, d);
      run(5);

      // fill port 0 past full, then drain
      arb_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         d = '0;
         d[0 +: W] = 32'h0F00_0000 + 32'(k);
         step(4'b0001, d);
      end
      arb_en = 1'b1;
      run(8);

      // two entries on every port, round-robin drain
      arb_en = 1'b0;
      arb_last = N - 1;
      for (int j = 0; j < 2; j++) begin
         for (int i = 0; i < N; i++) d[i*W +: W] = 32'(16 * i + j);
         step(4'b1111, d);
      end
      arb_en = 1'b1;
      run(12);

      // push and pop together on port 1 at count 3
      arb_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         d = '0;
         d[W +: W] = 32'h1100_0000 + 32'(k);
         step(4'b0010, d);
      end
      d = '0;
      d[W +: W] = 32'h1100_00FF;
      cyc(4'b0010, d, 4'b0010, er);
      arb_en = 1'b1;
      garb = '0;
      run(7);

      // grant to an empty port
      do_reset('0);
      cyc('0, '0, '0, er);
      cyc('0, '0, 4'b0010, er);
      cyc('0, '0, '0, er);
      cyc('0, '0, '0, er);

      // multi-hot grant with both ports non-empty
      do_reset('0);
      cyc('0, '0, '0, er);
      d = '0;
      d[0 +: W] = 32'h2222_0000;
      d[W +: W] = 32'h2222_0001;
      cyc(4'b0011, d, '0, er);
      cyc('0, '0, 4'b0011, er);
      arb_en = 1'b1;
      garb = '0;
      run(6);

      // reset with entries queued and a grant in flight
      do_reset('0);
      arb_en = 1'b1;
      step('0, '0);
      for (int i = 0; i < N; i++) d[i*W +: W] = 32'h3300_0000 + 32'(i);
      step(4'b0111, d);
      step('0, '0);
      gsave = garb;
      do_reset(gsave);
      cyc('0, '0, gsave, er);
      cyc('0, '0, '0, er);

      // randomized traffic
      do_reset('0);
      arb_en = 1'b1;
      step('0, '0);
      for (int c = 0; c < 600; c++) begin
         logic [N-1:0] v;
         logic [N-1:0] g;
         v = N'($urandom);
         for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
         g = ($urandom_range(0, 3) != 0) ? garb : '0;
         cyc(v, d, g, er);
         garb = rr(er);
      end
      run(40);
      @(negedge clk);
      #1;
      chk("sb_drained", 64'(sb.size()), 64'(0));
      for (int i = 0; i < N; i++)
         chk("model_empty", 64'(mq[i].size()), 64'(0));

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/arb_req_queue.md
# arb_req_queue

Requester-side companion to the round-robin arbiter. It holds per-port request FIFOs, drives the arbiter's `reqs` vector and consumes its registered one-hot `grants`. On each grant it pops the granted port's head entry onto a single shared output bus. The block sits between N producer ports and the shared resource guarded by the arbiter, so producers only ever see a valid/ready push interface.

## Interface
- `NUM_PORTS`, default 4: number of requester ports; must be ≥2.
- `DATA_W`, default 32: payload width per entry.
- `DEPTH`, default 4: entries per port FIFO; power of two, ≥2.
- `clk`  in  1  clock, all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  NUM_PORTS  per-port push request.
- `in_data`  in  NUM_PORTS*DATA_W  per-port payload; port i occupies bits [i*DATA_W +: DATA_W].
- `in_ready`  out  NUM_PORTS  per-port FIFO not full.
- `reqs`  out  NUM_PORTS  request vector to the arbiter.
- `grants`  in  NUM_PORTS  registered grant vector from the arbiter, expected one-hot or zero.
- `out_valid`  out  1  shared-bus entry valid, registered.
- `out_data`  out  DATA_W  popped payload, registered.
- `out_port`  out  $clog2(NUM_PORTS)  index of the port that was popped, registered.
- `grant_err`  out  1  sticky protocol-error flag.

## Operation
- Each port has a circular FIFO with write pointer, read pointer and count (0..DEPTH). The count is $clog2(DEPTH)+1 bits wide and pointers wrap modulo DEPTH.
- Push: on `in_valid[i] && in_ready[i]`, write `in_data` slice at wptr and increment wptr.
- `in_ready[i] = (count_i != DEPTH)`. It is based on the registered count only. A same-cycle pop does not raise ready.
- Request generation (combinational from registered state and `grants`):
  - `reqs[i] = count_i > (grants[i] ? 1 : 0)`.
  - Rationale: the arbiter samples `reqs` in the same cycle it presents the grant for the previous request. The port therefore drops its request in that cycle when the entry being granted is its last one. This prevents a spurious re-grant.
- Pop: when `grants` is exactly one-hot with bit i set and `count_i ≥ 1`:
  - Read the head entry and increment rptr.
  - Next cycle: `out_valid=1`, `out_data` = head entry, `out_port=i`.
  - Otherwise `out_valid=0` next cycle, and `out_data`/`out_port` hold their previous values.
- Simultaneous push and pop on the same port: the count is unchanged and both pointers advance. This is legal at count=DEPTH−1 but not at DEPTH, because ready is low when full.
- Protocol errors set `grant_err`, which stays 1 until reset. No pop occurs in the error cycle.
  - A grant to a port with count 0.
  - More than one grant bit set.
- No output backpressure: the shared resource must accept one entry per cycle.

## Timing
- Reset values:
  - All counts and pointers are 0.
  - `in_ready` is all-ones and `reqs` is 0.
  - `out_valid=0`, `out_data=0`, `out_port=0`, `grant_err=0`.
  - FIFO storage need not be reset.
- Reset mid-operation: all queued entries are discarded. Any grant arriving in the cycle after reset deassertion hits an empty FIFO. It must be ignored without setting `grant_err`; the block masks grants for exactly one cycle after reset.
- Latency with an idle arbiter:
  - Push accepted at cycle t; count=1 and `reqs[i]=1` at t+1.
  - Grant at t+2 (arbiter register); `reqs[i]` drops combinationally at t+2 if count was 1.
  - `out_valid` at t+3.
- Back-to-back: a port holding k entries, with no competing ports, gets one grant per cycle. It produces k consecutive `out_valid` cycles.
- Round-robin fairness comes from the arbiter. This block only guarantees that `reqs[i]` stays high while entries remain beyond the one currently being granted.

## Test plan
- Single push: push 0xA5A5_0001 on port 2 at cycle 5, with a model arbiter. Required: `reqs=4'b0100` at cycle 6, grant at 7, `reqs=0` at 7, then `out_valid=1`, `out_data=0xA5A5_0001`, `out_port=2` at 8. No second grant.
- Fill and full: push 5 entries to port 0 with no grants. Required: `in_ready[0]=0` after 4 accepted pushes and the 5th is not accepted. Enabling the arbiter then yields exactly 4 outputs in push order, on 4 consecutive cycles.
- Round-robin drain: all 4 ports each hold 2 entries (port i data = 0x10·i+j). Required: 8 outputs with `out_port` sequence 0,1,2,3,0,1,2,3, with `reqs` reaching 0 after the last grant.
- Simultaneous push and pop: port 1 at count 3 receives a push and a grant in the same cycle. Required: count stays 3, the output is the old head, and the pushed entry is emitted last.
- Protocol errors:
  - Inject `grants=4'b0010` while port 1 is empty. Required: `grant_err=1`, no `out_valid`, and the flag holds.
  - Separately, inject `grants=4'b0011` with both ports non-empty. Required: `grant_err=1` and both counts unchanged.
- Reset mid-operation: assert reset while 3 ports hold entries and a grant is in flight. Required: all outputs at reset values next cycle. The in-flight grant arriving in the first post-reset cycle sets neither `out_valid` nor `grant_err`.
